reg_dump_tx: RTL and testbench

//  Reader side of the 16-bit register bank: on command, reads registers 0..NUM_REGS-1 one at a time

---
 rtl/reg_dump_tx.sv | 155 +++++++++++++++
 tb/tb_reg_dump_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_tx.sv
// Debug readout of a 16-bit register bank: walks registers 0..NUM_REGS-1 through a
// select/data port and shifts each value out as a UART-style frame (start, 16 data LSB first, stop).
module reg_dump_tx #(
    parameter int NUM_REGS     = 8,
    parameter int CLKS_PER_BIT = 4,
    localparam int SEL_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [SEL_W-1:0] rd_sel_o,
    input  logic [15:0]      rd_data_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_REGS - 1);
    localparam logic [3:0]        BIT_LAST  = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_reg,  state_next;
    logic [SEL_W-1:0]   sel_reg,    sel_next;
    logic [15:0]        shift_reg,  shift_next;
    logic [BAUD_W-1:0]  baud_reg,   baud_next;
    logic [3:0]         bit_reg,    bit_next;
    logic               tx_reg,     tx_next;
    logic               busy_reg,   busy_next;
    logic               done_reg,   done_next;
    logic               baud_end;

    assign baud_end = (baud_reg == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            shift_reg <= '0;
            baud_reg  <= '0;
            bit_reg   <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            shift_reg <= shift_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        shift_next = shift_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        tx_next    = tx_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        // Abort wins over every other transition; the frame is cut wherever it is.
        if (state_reg != IDLE && abort_i) begin
            state_next = IDLE;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
            baud_next  = '0;
            bit_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_next = 1'b1;
                    if (start_i) begin
                        sel_next   = '0;
                        busy_next  = 1'b1;
                        state_next = LOAD;
                    end
                end
                LOAD: begin
                    // rd_sel_o has been stable for a full cycle, so rd_data_i is valid here.
                    shift_next = rd_data_i;
                    tx_next    = 1'b0;
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = START;
                end
                START: begin
                    if (baud_end) begin
                        baud_next  = '0;
                        tx_next    = shift_reg[0];
                        state_next = DATA;
                    end else begin
                        baud_next = baud_reg + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_next = '0;
                        if (bit_reg == BIT_LAST) begin
                            bit_next   = '0;
                            tx_next    = 1'b1;
                            state_next = STOP;
                        end else begin
                            shift_next = {1'b0, shift_reg[15:1]};
                            tx_next    = shift_reg[1];
                            bit_next   = bit_reg + 4'd1;
                        end
                    end else begin
                        baud_next = baud_reg + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_next = '0;
                        if (sel_reg == SEL_LAST) begin
                            done_next  = 1'b1;
                            busy_next  = 1'b0;
                            state_next = IDLE;
                        end else begin
                            sel_next   = sel_reg + SEL_W'(1);
                            state_next = LOAD;
                        end
                    end else begin
                        baud_next = baud_reg + BAUD_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

    assign rd_sel_o = sel_reg;
    assign tx_o     = tx_reg;
    assign busy_o   = busy_reg;
    assign done_o   = done_reg;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: table-driven and randomized dumps on a 2-register/4-clk instance,
// plus a 1-register/1-clk instance for the edge-parameter case.
module tb_reg_dump_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, abort_a, start_b, abort_b;
    logic [0:0]  rd_sel_a, rd_sel_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic        tx_a, busy_a, done_a, tx_b, busy_b, done_b;
    logic [15:0] regs_a [0:1];
    logic [15:0] regs_b [0:1];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign rd_data_a = regs_a[rd_sel_a];
    assign rd_data_b = regs_b[rd_sel_b];

    reg_dump_tx #(.NUM_REGS(2), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .reset(reset), .start_i(start_a), .abort_i(abort_a),
        .rd_sel_o(rd_sel_a), .rd_data_i(rd_data_a),
        .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a)
    );

    reg_dump_tx #(.NUM_REGS(1), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .reset(reset), .start_i(start_b), .abort_i(abort_b),
        .rd_sel_o(rd_sel_b), .rd_data_i(rd_data_b),
        .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b)
    );

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        int          start_k;
        int          late_k;
        int          late_reg;
        logic [15:0] late_val;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic get_tx(input int which);
        return (which == 0) ? tx_a : tx_b;
    endfunction
    function automatic logic get_busy(input int which);
        return (which == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic get_done(input int which);
        return (which == 0) ? done_a : done_b;
    endfunction
    function automatic int get_sel(input int which);
        return (which == 0) ? int'(rd_sel_a) : int'(rd_sel_b);
    endfunction

    task automatic set_start(input int which, input logic v);
        if (which == 0) start_a = v;
        else start_b = v;
    endtask

    task automatic set_reg(input int which, input int idx, input logic [15:0] v);
        if (which == 0) regs_a[idx] = v;
        else regs_b[idx] = v;
    endtask

    // One complete dump: the expected line is built frame by frame from the words,
    // then the recorded line is decoded at bit centres and compared with the table.
    task automatic run_dump(input int which, input int n, input int c,
                            input logic [15:0] w0, input logic [15:0] w1,
                            input int start_k, input int late_k, input int late_reg,
                            input logic [15:0] late_val,
                            input logic [15:0] exp0, input logic [15:0] exp1,
                            input string tag);
        logic        ew [$];
        logic        rec [$];
        logic [15:0] words [2];
        logic [15:0] dec [2];
        int          total, blk, bad_k, done_seen;
        words[0] = w0;
        words[1] = w1;
        blk   = 1 + 18 * c;
        total = n * blk;
        for (int r = 0; r < n; r++) begin
            ew.push_back(1'b1);
            for (int j = 0; j < c; j++) ew.push_back(1'b0);
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < c; j++) ew.push_back(words[r][i]);
            for (int j = 0; j < c; j++) ew.push_back(1'b1);
        end
        set_reg(which, 0, w0);
        set_reg(which, 1, w1);
        set_start(which, 1'b1);
        tick();
        set_start(which, 1'b0);
        bad_k = -1;
        done_seen = 0;
        for (int k = 0; k < total; k++) begin
            rec.push_back(get_tx(which));
            if (get_done(which)) done_seen++;
            if (bad_k < 0 && (get_tx(which) !== ew[k] || get_busy(which) !== 1'b1 ||
                              get_sel(which) != k / blk))
                bad_k = k;
            set_start(which, k == start_k);
            if (k == late_k) set_reg(which, late_reg, late_val);
            tick();
        end
        check({tag, " wave first bad cycle"}, bad_k, -1);
        check({tag, " done during dump"}, done_seen, 0);
        check({tag, " done at end"}, get_done(which), 1'b1);
        check({tag, " busy at end"}, get_busy(which), 1'b0);
        check({tag, " tx at end"}, get_tx(which), 1'b1);
        check({tag, " sel at end"}, get_sel(which), n - 1);
        set_start(which, 1'b0);
        for (int r = 0; r < n; r++)
            for (int i = 0; i < 16; i++)
                dec[r][i] = rec[r * blk + 1 + c * (i + 1) + c / 2];
        check({tag, " frame0"}, dec[0], exp0);
        if (n > 1) check({tag, " frame1"}, dec[1], exp1);
        tick();
        check({tag, " done one cycle"}, get_done(which), 1'b0);
        check({tag, " idle after"}, get_busy(which), 1'b0);
        $display("dump %s: regs %04h %04h decoded %04h %04h", tag, w0, w1, dec[0],
                 (n > 1) ? dec[1] : 16'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        int bad;
        logic [15:0] rw0, rw1, rlv;
        int rsk, rlk, rlr;

        vecs[0] = '{16'hA5C3, 16'h0001, -1,  -1, 0, 16'h0000, 16'hA5C3, 16'h0001};
        vecs[1] = '{16'h1234, 16'hFEDC, 50,  -1, 0, 16'h0000, 16'h1234, 16'hFEDC};
        vecs[2] = '{16'hFFFF, 16'h5555, -1,   1, 0, 16'h0000, 16'hFFFF, 16'h5555};
        vecs[3] = '{16'h0000, 16'hFFFF, 145, -1, 0, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[4] = '{16'h8001, 16'h7FFE, 10,  100, 1, 16'h1111, 16'h8001, 16'h7FFE};

        reset = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        regs_a[0] = 16'h0; regs_a[1] = 16'h0; regs_b[0] = 16'h0; regs_b[1] = 16'h0;
        tick();
        tick();
        check("reset tx", tx_a, 1'b1);
        check("reset busy", busy_a, 1'b0);
        check("reset done", done_a, 1'b0);
        check("reset sel", rd_sel_a, 1'b0);
        reset = 1'b1;
        tick();

        for (int v = 0; v < 5; v++)
            run_dump(0, 2, 4, vecs[v].w0, vecs[v].w1, vecs[v].start_k, vecs[v].late_k,
                     vecs[v].late_reg, vecs[v].late_val, vecs[v].exp0, vecs[v].exp1,
                     $sformatf("vec%0d", v));

        // Abort during bit 7 of frame 0 (cycles 33..36 after the accepting edge).
        regs_a[0] = 16'h0000; regs_a[1] = 16'hFFFF;
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (34) tick();
        check("abort tx before", tx_a, 1'b0);
        abort_a = 1'b1; tick(); abort_a = 1'b0;
        check("abort tx", tx_a, 1'b1);
        check("abort busy", busy_a, 1'b0);
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            if (done_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
            tick();
        end
        check("abort quiet cycles", bad, 0);
        $display("abort in frame 0 bit 7: line idle, busy %0b", busy_a);

        // Abort in frame 1, then a fresh dump must restart at register 0.
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (90) tick();
        check("sel in frame1", rd_sel_a, 1'b1);
        abort_a = 1'b1; tick(); abort_a = 1'b0;
        check("abort1 busy", busy_a, 1'b0);
        $display("abort in frame 1: busy %0b", busy_a);
        run_dump(0, 2, 4, 16'hC0DE, 16'hBEEF, -1, -1, 0, 16'h0, 16'hC0DE, 16'hBEEF, "redump");

        // Abort in IDLE changes nothing.
        abort_a = 1'b1; repeat (3) tick(); abort_a = 1'b0;
        check("abort idle busy", busy_a, 1'b0);
        check("abort idle tx", tx_a, 1'b1);

        // Reset mid-DATA of frame 1 acts before the next edge.
        regs_a[0] = 16'hFFFF; regs_a[1] = 16'h0000;
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (100) tick();
        check("pre-reset tx", tx_a, 1'b0);
        reset = 1'b0;
        #1;
        check("async reset tx", tx_a, 1'b1);
        check("async reset busy", busy_a, 1'b0);
        check("async reset sel", rd_sel_a, 1'b0);
        tick(); tick();
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check("post-reset idle", bad, 0);
        $display("reset mid-frame: tx %0b busy %0b", tx_a, busy_a);

        for (int r = 0; r < 6; r++) begin
            rw0 = 16'($urandom);
            rw1 = 16'($urandom);
            rlv = 16'($urandom);
            rsk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 144)) : -1;
            rlr = int'($urandom_range(0, 1));
            rlk = (rlr == 0) ? int'($urandom_range(1, 145)) : int'($urandom_range(74, 145));
            run_dump(0, 2, 4, rw0, rw1, rsk, rlk, rlr, rlv, rw0, rw1, $sformatf("rand%0d", r));
        end

        run_dump(1, 1, 1, 16'h8000, 16'h0, -1, -1, 0, 16'h0, 16'h8000, 16'h0, "edge1");
        run_dump(1, 1, 1, 16'h8000, 16'h0, -1, -1, 0, 16'h0, 16'h8000, 16'h0, "edge2");
        rw0 = 16'($urandom);
        run_dump(1, 1, 1, rw0, 16'h0, 5, -1, 0, 16'h0, rw0, 16'h0, "edge_rand");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
